// File: rtl/mulinc_decoder_pkg.sv
// rtl/mulinc_decoder_pkg.sv - shared types, defaults and wrap-subtract helper for the mul/inc decoder
package mulinc_pkg;

  localparam int DEFAULT_W = 2;
  localparam int MAX_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    MUL,
    DONE
  } state_t;

  // Subtract at the widest legal operand width; callers keep the low W bits,
  // which is exactly the W-bit wrap-around difference.
  function automatic logic [MAX_W-1:0] wrap_sub(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/mulinc_decoder_if.sv
// rtl/mulinc_decoder_if.sv - tuple-in / result-out handshake bundle of the mul/inc decoder
interface mulinc_decoder_if import mulinc_pkg::*; #(
  parameter int W = DEFAULT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic         z;
  logic [W-1:0] u;
  logic [W-1:0] w;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         match;

  // Producer/consumer side that feeds tuples and drains results.
  modport master (
    output in_valid, x, z, u, w, out_ready,
    input  in_ready, out_valid, y, match
  );

  // Decoder side.
  modport slave (
    input  in_valid, x, z, u, w, out_ready,
    output in_ready, out_valid, y, match
  );

endinterface

// File: rtl/mulinc_decoder_serial_mul.sv
// rtl/mulinc_decoder_serial_mul.sv - W-cycle bit-serial shift-add multiplier, product mod 2^W
module serial_mul_modw import mulinc_pkg::*; #(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST = IW'(W - 1);

  logic [W-1:0]  x_r;
  logic [W-1:0]  y_r;
  logic [W-1:0]  acc;
  logic [IW-1:0] idx;

  // done flags the cycle whose edge performs the final partial-product add,
  // so acc holds the full product right after it.
  assign done    = busy && (idx == LAST);
  assign product = acc;

  // Load operands on start, then add one shifted partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r  <= '0;
      y_r  <= '0;
      acc  <= '0;
      idx  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      x_r  <= x;
      y_r  <= y;
      acc  <= '0;
      idx  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (x_r[idx]) begin
        acc <= acc + (y_r << idx);
      end
      idx <= idx + 1'b1;
      if (idx == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mulinc_decoder.sv
// rtl/mulinc_decoder.sv - recovers y = w - z and checks x*y == u; MULINC_DEC_STATS_EN adds mismatch_cnt
module mulinc_decoder import mulinc_pkg::*; #(
  parameter int W  = DEFAULT_W,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  mulinc_decoder_if.slave bus
`ifdef MULINC_DEC_STATS_EN
  ,
  output logic [CW-1:0] mismatch_cnt
`endif
);

  state_t       state;
  logic [W-1:0] x_r;
  logic [W-1:0] u_r;
  logic [W-1:0] w_r;
  logic         z_r;
  logic [W-1:0] y_r;

  logic         mul_start;
  logic         mul_busy;
  logic         mul_done;
  logic [W-1:0] product;
  logic [W-1:0] y_next;

  assign y_next    = W'(wrap_sub(MAX_W'(w_r), MAX_W'(z_r)));
  assign mul_start = (state == SUB) && !mul_busy;

  serial_mul_modw #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .x       (x_r),
    .y       (y_next),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  assign bus.y     = y_r;
  assign bus.match = bus.out_valid && (product == u_r);

  // Control FSM: accept a tuple, recover y, run the multiplier, hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      x_r           <= '0;
      u_r           <= '0;
      w_r           <= '0;
      z_r           <= 1'b0;
      y_r           <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            x_r          <= bus.x;
            u_r          <= bus.u;
            w_r          <= bus.w;
            z_r          <= bus.z;
            bus.in_ready <= 1'b0;
            state        <= SUB;
          end
        end
        SUB: begin
          y_r   <= y_next;
          state <= MUL;
        end
        MUL: begin
          if (mul_done) begin
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MULINC_DEC_STATS_EN
  // Count delivered mismatching results, holding at the counter's maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && !bus.match && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mulinc_decoder.sv
// tb/tb_mulinc_decoder.sv - randomized and directed self-check of mulinc_decoder at W=2 and W=8
module tb_mulinc_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst8;
  int   total = 0;
  int   bad   = 0;
  int   outs8 = 0;
  int   cm2   = 0;
  int   cm8   = 0;

  mulinc_decoder_if #(.W(2)) b2();
  mulinc_decoder_if #(.W(8)) b8();

`ifdef MULINC_DEC_STATS_EN
  logic [7:0] cnt2;
  logic [3:0] cnt8;
`endif

  mulinc_decoder #(.W(2), .CW(8)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (b2.slave)
`ifdef MULINC_DEC_STATS_EN
    ,
    .mismatch_cnt (cnt2)
`endif
  );

  mulinc_decoder #(.W(8), .CW(4)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (b8.slave)
`ifdef MULINC_DEC_STATS_EN
    ,
    .mismatch_cnt (cnt8)
`endif
  );

  typedef struct {
    logic [15:0] y;
    bit          m;
  } exp_t;

  exp_t q2[$];
  exp_t q8[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_y(input int wd, input int unsigned wv, input int unsigned zv);
    return 16'((wv - zv) & ((32'd1 << wd) - 1));
  endfunction

  function automatic bit ref_m(input int wd, input int unsigned xv, input int unsigned yv,
                               input int unsigned uv);
    return ((xv * yv) & ((32'd1 << wd) - 1)) == uv;
  endfunction

  // Compare current outputs with the model, then advance the model by what the next edge will do.
  always @(negedge clk) begin
    exp_t e;
    if (b2.out_valid) begin
      if (q2.size() == 0) chk("m2_spurious_out", b2.out_valid, 0);
      else begin
        chk("m2_y", b2.y, q2[0].y);
        chk("m2_match", b2.match, q2[0].m);
      end
    end
    if (b8.out_valid) begin
      if (q8.size() == 0) chk("m8_spurious_out", b8.out_valid, 0);
      else begin
        chk("m8_y", b8.y, q8[0].y);
        chk("m8_match", b8.match, q8[0].m);
      end
    end
`ifdef MULINC_DEC_STATS_EN
    chk("m2_cnt", cnt2, cm2);
    chk("m8_cnt", cnt8, cm8);
`endif
    if (rst2) begin
      q2.delete();
      cm2 = 0;
    end else begin
      if (b2.out_valid && b2.out_ready && q2.size() > 0) begin
        if (!q2[0].m && cm2 < 255) cm2++;
        void'(q2.pop_front());
      end
      if (b2.in_valid && b2.in_ready) begin
        e.y = ref_y(2, b2.w, b2.z);
        e.m = ref_m(2, b2.x, e.y, b2.u);
        q2.push_back(e);
      end
    end
    if (rst8) begin
      q8.delete();
      cm8 = 0;
    end else begin
      if (b8.out_valid && b8.out_ready && q8.size() > 0) begin
        if (!q8[0].m && cm8 < 15) cm8++;
        outs8++;
        void'(q8.pop_front());
      end
      if (b8.in_valid && b8.in_ready) begin
        e.y = ref_y(8, b8.w, b8.z);
        e.m = ref_m(8, b8.x, e.y, b8.u);
        q8.push_back(e);
      end
    end
  end

  task automatic send2(input logic [1:0] xv, input logic zv, input logic [1:0] uv, input logic [1:0] wv);
    int k = 0;
    @(posedge clk); #1;
    b2.in_valid = 1'b1; b2.x = xv; b2.z = zv; b2.u = uv; b2.w = wv;
    do begin
      @(negedge clk);
      k++;
    end while (!b2.in_ready && k < 50);
    chk("send2_accept", b2.in_ready, 1);
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    b2.x = 2'($urandom); b2.z = 1'($urandom); b2.u = 2'($urandom); b2.w = 2'($urandom);
  endtask

  task automatic wait_out2(input string tag, input logic [1:0] ey, input logic em, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b2.out_valid && n < 30);
    chk({tag, "_valid"}, b2.out_valid, 1);
    chk({tag, "_y"}, b2.y, ey);
    chk({tag, "_match"}, b2.match, em);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      b8.out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    int n;
    int k;
    logic [1:0] sy;
    logic sm;
    logic [7:0] xx, yy, uu, ww;
    logic zz;
    rst2 = 1'b1; rst8 = 1'b1;
    b2.in_valid = 0; b2.x = 0; b2.z = 0; b2.u = 0; b2.w = 0; b2.out_ready = 1'b1;
    b8.in_valid = 0; b8.x = 0; b8.z = 0; b8.u = 0; b8.w = 0; b8.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", b2.in_ready, 0);
    chk("rst_out_valid", b2.out_valid, 0);
    chk("rst_y", b2.y, 0);
    chk("rst_match", b2.match, 0);
`ifdef MULINC_DEC_STATS_EN
    chk("rst_cnt", cnt2, 0);
`endif
    @(posedge clk); #1;
    rst2 = 1'b0; rst8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", b2.in_ready, 1);

    send2(2'd3, 1'b1, 2'd2, 2'd3);
    wait_out2("t1", 2'd2, 1'b1, n);
    chk("t1_latency", n, 4);
    @(posedge clk);
    @(negedge clk);
    chk("t1_released", b2.out_valid, 0);
    chk("t1_ready_back", b2.in_ready, 1);

    send2(2'd3, 1'b1, 2'd1, 2'd3);
    wait_out2("t2", 2'd2, 1'b0, n);
    @(posedge clk);
    @(negedge clk);
`ifdef MULINC_DEC_STATS_EN
    chk("t2_cnt", cnt2, 1);
`endif

    send2(2'd0, 1'b1, 2'd0, 2'd0);
    wait_out2("t3a", 2'd3, 1'b1, n);
    send2(2'd0, 1'b1, 2'd1, 2'd0);
    wait_out2("t3b", 2'd3, 1'b0, n);

    @(posedge clk); #1;
    b2.out_ready = 1'b0;
    send2(2'd1, 1'b0, 2'd3, 2'd3);
    wait_out2("bp", 2'd3, 1'b1, n);
    sy = b2.y;
    sm = b2.match;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b2.in_valid = 1'($urandom);
      b2.x = 2'($urandom); b2.u = 2'($urandom); b2.w = 2'($urandom);
      @(negedge clk);
      chk("bp_valid", b2.out_valid, 1);
      chk("bp_y_hold", b2.y, sy);
      chk("bp_match_hold", b2.match, sm);
      chk("bp_in_ready", b2.in_ready, 0);
    end
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    b2.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released", b2.out_valid, 0);

    send2(2'd2, 1'b0, 2'd0, 2'd1);
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", b2.out_valid, 0);
    chk("mid_rst_ready", b2.in_ready, 0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", b2.in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      chk("no_partial", b2.out_valid, 0);
    end
    send2(2'd3, 1'b0, 2'd1, 2'd3);
    wait_out2("after_rst", 2'd3, 1'b1, n);
    @(posedge clk);
    @(negedge clk);
`ifdef MULINC_DEC_STATS_EN
    chk("after_rst_cnt", cnt2, 0);
`endif

    for (int t = 0; t < 1000; t++) begin
      @(posedge clk); #1;
      xx = 8'($urandom); zz = 1'($urandom); ww = 8'($urandom);
      yy = ww - 8'(zz);
      uu = ($urandom % 2) ? 8'(xx * yy) : 8'($urandom);
      b8.in_valid = 1'b1; b8.x = xx; b8.z = zz; b8.u = uu; b8.w = ww;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!b8.in_ready && k < 100);
      if (k >= 100) chk("sweep_accept", b8.in_ready, 1);
      @(posedge clk); #1;
      b8.in_valid = 1'b0;
      b8.x = 8'($urandom); b8.z = 1'($urandom); b8.u = 8'($urandom); b8.w = 8'($urandom);
    end
    k = 0;
    while (q8.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("sweep_drain", q8.size(), 0);
    chk("sweep_outputs", outs8, 1000);
`ifdef MULINC_DEC_STATS_EN
    chk("sweep_cnt_sat", cnt8, 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mulinc_decoder.md
Name: mulinc_decoder

Overview:
- Inverse end of the 2-bit "mul/inc" encoder pair, where u = x*y mod 2^W and w = y + z mod 2^W.
- Takes an encoded tuple (x, z, u, w), recovers y = (w - z) mod 2^W, then checks that x*y mod 2^W equals u.
- Multi-cycle, bit-serial shift-add multiplier behind a valid/ready handshake on both sides.
- Sits downstream of the encoder in the equivalence/regression harness.

Parameters:
- W, 2, operand width in bits (legal 1..16).
- CW, 8, width of the optional mismatch counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  decoder can accept a tuple.
- x  in  W  multiplier operand.
- z  in  1  increment bit.
- u  in  W  encoded product.
- w  in  W  encoded sum.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  W  recovered operand.
- match  out  1  1 when x*y mod 2^W == u.
- mismatch_cnt  out  CW  present only with MULINC_DEC_STATS_EN.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; out_valid=0, y=0, match=0, mismatch_cnt=0. All internal registers are cleared.
- FSM states: IDLE, SUB, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch x, z, u, w and go to SUB.
- SUB (1 cycle):
  - y_r <= (w_r - z_r) mod 2^W, computed as W-bit wrap-around.
  - acc <= 0, bit index i <= 0, go to MUL.
- MUL (exactly W cycles):
  - Each cycle, if x_r[i] then acc <= (acc + (y_r << i)) mod 2^W.
  - i++. After the cycle with i==W-1, go to DONE.
- DONE:
  - out_valid=1; y=y_r; match=(acc==u_r).
  - Outputs hold stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE. in_ready rises in the following cycle, so there is no same-cycle re-accept.
- Latency: acceptance edge to out_valid high = W+2 cycles. Throughput is one tuple per W+3 cycles with out_ready held high.
- in_ready=0 in SUB, MUL and DONE. in_valid in those states is ignored and its data is not captured.
- Wrap-around cases:
  - w=0, z=1 gives y=2^W-1.
  - x=0 gives acc=0, so match=(u==0).
- rst asserted mid-operation: FSM returns to IDLE the next edge, out_valid drops, the in-flight tuple is discarded and no partial result is emitted.
- Inputs x, z, u, w are sampled only at acceptance. Later changes do not affect the result.

Optional Feature:
- Macro: MULINC_DEC_STATS_EN.
- Defined:
  - Adds port mismatch_cnt.
  - Increments by 1 on each output handshake with match=0.
  - Saturates at 2^CW-1; no wrap.
  - Cleared by rst.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package mulinc_pkg holds:
  - state enum (IDLE, SUB, MUL, DONE);
  - default W;
  - a function for the W-bit wrap subtract.
- One natural sub-module: serial_mul_modw, the W-cycle shift-add multiplier.
  - Interface: start, x, y, busy, done, product.
  - The top instantiates it from the MUL state.

Test Plan:
- W=2: x=3, z=1, u=2, w=3, out_ready=1 → y=2, match=1; out_valid first high 4 cycles after acceptance.
- W=2: x=3, z=1, u=1, w=3 → y=2, match=0; with STATS_EN, mismatch_cnt=1.
- W=2: x=0, z=1, u=0, w=0 → y=3 (wrap), match=1. Then u=1 with the same other inputs → match=0.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid, y and match stay constant and in_ready=0. in_valid pulses during that window are not accepted.
- rst pulsed during MUL → next cycle out_valid=0 and FSM in IDLE; in_ready=1 one cycle after rst deasserts. A new tuple then completes normally.
- W=8 random sweep of 1000 tuples, STATS_EN defined, CW=4 → each y equals w-z mod 256 and match equals the reference model. mismatch_cnt saturates at 15.
